// File: rtl/exp_golomb_encoder.sv
// Exp-Golomb bitstream encoder: turns ue/se/te/u8 symbols into codewords and
// packs them MSB-first into 16-bit words for the matching decoder.
module exp_golomb_encoder #(
  parameter logic PAD_BIT = 1'b0,
  parameter int   ACC_W   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_value,
  input  logic [1:0]  exp_golomb_sel,
  input  logic        flush,
  output logic [15:0] bs_word,
  output logic        bs_valid,
  input  logic        bs_ready,
  output logic        flush_done,
  output logic [5:0]  fill_level
);

  localparam logic [1:0] SEL_UE = 2'b00;
  localparam logic [1:0] SEL_SE = 2'b01;
  localparam logic [1:0] SEL_TE = 2'b10;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc;

  logic [7:0]         neg8;
  logic [8:0]         code_num;
  logic [9:0]         cn1;
  logic [3:0]         m;
  logic [16:0]        code_bits;
  logic [4:0]         code_len;
  logic [5:0]         ins_sh;
  logic [ACC_W-1:0]   ins_bits;
  logic [15:0]        pad_mask;
  logic               do_acc, do_xfer, do_pad;

  // Codeword generation. ue/se codewords are just codeNum+1 written in 2M+1
  // bits; the M leading zeros fall out of the zero extension.
  always_comb begin
    neg8     = 8'd0 - in_value;
    code_num = {1'b0, in_value};
    if (exp_golomb_sel == SEL_SE)
      code_num = ($signed(in_value) > 0) ? ({in_value, 1'b0} - 9'd1) : {neg8, 1'b0};
    cn1 = {1'b0, code_num} + 10'd1;
    m   = 4'd0;
    for (int i = 1; i < 10; i++)
      if (cn1[i]) m = 4'(i);
    case (exp_golomb_sel)
      SEL_UE, SEL_SE: begin
        code_bits = 17'(cn1);
        code_len  = {m, 1'b0} + 5'd1;
      end
      SEL_TE: begin
        code_bits = {16'b0, ~in_value[0]};
        code_len  = 5'd1;
      end
      default: begin
        code_bits = {9'b0, in_value};
        code_len  = 5'd8;
      end
    endcase
  end

  // Left-justify the codeword, then drop it just below the current fill point.
  always_comb begin
    ins_sh   = 6'(ACC_W) - {1'b0, code_len};
    ins_bits = (ACC_W'(code_bits) << ins_sh) >> fill_level;
    pad_mask = 16'hFFFF >> fill_level[3:0];
  end

  assign bs_valid = (fill_level >= 6'd16);
  assign bs_word  = acc[ACC_W-1 -: 16];
  assign in_ready = (state_q == S_RUN) && (fill_level <= 6'd15) && reset_n;
  assign do_acc   = in_valid && in_ready;
  assign do_xfer  = bs_valid && bs_ready;
  assign do_pad   = (state_q == S_FLUSH) && (fill_level != 6'd0) && (fill_level < 6'd16);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_RUN:   if (flush) state_d = S_FLUSH;
      S_FLUSH: if (fill_level == 6'd0) begin
        flush_done = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Transfer and accept never coincide: one needs fill>=16, the other fill<=15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      fill_level <= '0;
    end else if (do_xfer) begin
      acc        <= acc << 16;
      fill_level <= fill_level - 6'd16;
    end else if (do_acc) begin
      acc        <= acc | ins_bits;
      fill_level <= fill_level + 6'(code_len);
    end else if (do_pad) begin
      acc[ACC_W-1 -: 16] <= acc[ACC_W-1 -: 16] | (PAD_BIT ? pad_mask : 16'h0000);
      fill_level         <= 6'd16;
    end
  end

endmodule
